conv_encoder_framed: RTL

- Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of viterbi_decoder.
- Accepts a framed serial bit stream over a valid/ready handshake and emits one 2-bit code symbol per accepted bit.
- Appends K-1 = 2 zero tail bits per frame so every frame terminates in trellis state 00.
- Its cx output drives viterbi_decoder's cx input directly, one symbol per clk.

---
 rtl/viterbi_pkg.sv | 21 ++
 rtl/conv_encoder_framed_if.sv | 22 ++
 rtl/conv_enc_core.sv | 21 ++
 rtl/conv_encoder_framed.sv | 134 +++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Constants shared by the convolutional encoder and the Viterbi decoder:
// constraint length, generator polynomials and the framing FSM encoding.
package viterbi_pkg;

  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TAIL1 = 2'd2,
    TAIL2 = 2'd3
  } enc_state_e;

  // Modulo-2 sum of the taps selected by a generator mask.
  function automatic logic parity(input logic [K-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/conv_encoder_framed_if.sv
// Bit-stream input handshake and code-symbol output of the framed encoder.
interface conv_encoder_framed_if;

  logic       d;
  logic       d_valid;
  logic       d_ready;
  logic [1:0] cx;
  logic       cx_valid;
  logic       sof;
  logic       eof;

  modport slave (
    input  d, d_valid,
    output d_ready, cx, cx_valid, sof, eof
  );

  modport master (
    output d, d_valid,
    input  d_ready, cx, cx_valid, sof, eof
  );

endinterface

// File: rtl/conv_enc_core.sv
// Combinational rate-1/2, K=3 trellis step: (b, {s1,s0}) -> (cx, next state).
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic       b,
  input  logic [1:0] s,
  output logic [1:0] cx,
  output logic [1:0] s_next
);

  logic [K-1:0] win;

  // win[2] is the new bit, win[1] = s1, win[0] = s0, aligned with the generator masks.
  always_comb begin
    win    = {b, s};
    cx[1]  = parity(win & G0);
    cx[0]  = parity(win & G1);
    s_next = {b, s[1]};
  end

endmodule

// File: rtl/conv_encoder_framed.sv
// Framed convolutional encoder: one registered symbol per accepted bit,
// followed by two zero tail symbols that drive the trellis back to state 00.
module conv_encoder_framed
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int CW        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_encoder_framed_if.slave bus,
  output logic                 busy
);

  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  enc_state_e    state_q, state_d;
  logic [1:0]    s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cx_q, cx_d;
  logic          cx_valid_q, cx_valid_d;
  logic          sof_q, sof_d;
  logic          eof_q, eof_d;
  logic          d_ready_q, d_ready_d;
  logic          busy_q, busy_d;

  logic          accept;
  logic          enc_b;
  logic [1:0]    enc_cx;
  logic [1:0]    enc_s_next;
  logic [CW-1:0] cnt_inc;

  // Tail states feed zeros so the trellis is flushed regardless of bus.d.
  assign enc_b   = ((state_q == IDLE) || (state_q == DATA)) ? bus.d : 1'b0;
  assign accept  = bus.d_valid & d_ready_q;
  assign cnt_inc = cnt_q + ONE_CNT;

  conv_enc_core u_core (
    .b      (enc_b),
    .s      (s_q),
    .cx     (enc_cx),
    .s_next (enc_s_next)
  );

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    cnt_d      = cnt_q;
    cx_d       = cx_q;
    cx_valid_d = 1'b0;
    sof_d      = sof_q;
    eof_d      = eof_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cx_d       = enc_cx;
          s_d        = enc_s_next;
          cx_valid_d = 1'b1;
          sof_d      = 1'b1;
          eof_d      = 1'b0;
          cnt_d      = ONE_CNT;
          state_d    = (LAST_CNT == ONE_CNT) ? TAIL1 : DATA;
        end
      end
      DATA: begin
        if (accept) begin
          cx_d       = enc_cx;
          s_d        = enc_s_next;
          cx_valid_d = 1'b1;
          sof_d      = 1'b0;
          eof_d      = 1'b0;
          cnt_d      = cnt_inc;
          if (cnt_inc == LAST_CNT) state_d = TAIL1;
        end
      end
      TAIL1: begin
        cx_d       = enc_cx;
        s_d        = enc_s_next;
        cx_valid_d = 1'b1;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        state_d    = TAIL2;
      end
      TAIL2: begin
        cx_d       = enc_cx;
        s_d        = 2'b00;
        cx_valid_d = 1'b1;
        sof_d      = 1'b0;
        eof_d      = 1'b1;
        cnt_d      = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Ready and busy are decoded from the next state only, never from d_valid.
    d_ready_d = (state_d == IDLE) || (state_d == DATA);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      s_q        <= 2'b00;
      cnt_q      <= '0;
      cx_q       <= 2'b00;
      cx_valid_q <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      d_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      cx_q       <= cx_d;
      cx_valid_q <= cx_valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      d_ready_q  <= d_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.d_ready  = d_ready_q;
  assign bus.cx       = cx_q;
  assign bus.cx_valid = cx_valid_q;
  assign bus.sof      = sof_q;
  assign bus.eof      = eof_q;
  assign busy         = busy_q;

endmodule
